// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the pipelined TMDS 8b/10b channel encoder.
// Holds the control-period codes, the symbol width and the disparity counter width.
package tmds_pkg;

    localparam int SYM_W = 10;
    localparam int CNT_W = 5;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [1:0] ctrl);
        logic [SYM_W-1:0] sym;
        case (ctrl)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Combinational population count of an 8-bit word (result 0..8).
module tmds_popcount8 (
    input  logic [7:0] din,
    output logic [3:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, din[i]};
        end
    end

endmodule

// File: rtl/tmds_encoder_pipe.sv
// DVI TMDS 8b/10b encoder for one colour channel, three register stages on the pixel clock:
// input + N1(D), transition-minimised qm + N1/N0(qm), DC-balanced 10-bit symbol.
module tmds_encoder_pipe
    import tmds_pkg::*;
#(
    parameter bit C_dc_reset_on_blank = 1'b1
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_ctrl,
    input  logic             in_blank,
    output logic [SYM_W-1:0] out_symbol
);

    localparam logic signed [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [7:0]              data_p1_d, data_p1_q;
    logic [1:0]              ctrl_p1_d, ctrl_p1_q;
    logic                    blank_p1_d, blank_p1_q;
    logic [3:0]              n1d_p1_d, n1d_p1_q;

    logic                    use_xnor;
    logic [8:0]              qm_p2_d, qm_p2_q;
    logic [3:0]              n1q_p2_d, n1q_p2_q;
    logic [3:0]              n0q_p2_d, n0q_p2_q;
    logic [1:0]              ctrl_p2_d, ctrl_p2_q;
    logic                    blank_p2_d, blank_p2_q;

    logic                    qm8;
    logic signed [CNT_W-1:0] n1s, n0s, diff;
    logic [SYM_W-1:0]        sym_d, sym_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;

    // ---- stage 1: capture pixel and count its ones
    tmds_popcount8 u_pop_data (
        .din (in_data),
        .cnt (n1d_p1_d)
    );

    always_comb begin
        data_p1_d  = in_data;
        ctrl_p1_d  = in_ctrl;
        blank_p1_d = in_blank;
    end

    always_ff @(posedge clk_pixel) begin
        data_p1_q <= data_p1_d;
        n1d_p1_q  <= n1d_p1_d;
        if (reset) begin
            blank_p1_q <= 1'b1;
            ctrl_p1_q  <= 2'b00;
        end else begin
            blank_p1_q <= blank_p1_d;
            ctrl_p1_q  <= ctrl_p1_d;
        end
    end

    // ---- stage 2: transition minimisation
    always_comb begin
        use_xnor   = (n1d_p1_q > 4'd4) || ((n1d_p1_q == 4'd4) && !data_p1_q[0]);
        qm_p2_d    = '0;
        qm_p2_d[0] = data_p1_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_p2_d[i] = use_xnor ? ~(qm_p2_d[i-1] ^ data_p1_q[i])
                                  :  (qm_p2_d[i-1] ^ data_p1_q[i]);
        end
        qm_p2_d[8] = ~use_xnor;
        n0q_p2_d   = 4'd8 - n1q_p2_d;
        ctrl_p2_d  = ctrl_p1_q;
        blank_p2_d = blank_p1_q;
    end

    tmds_popcount8 u_pop_qm (
        .din (qm_p2_d[7:0]),
        .cnt (n1q_p2_d)
    );

    always_ff @(posedge clk_pixel) begin
        qm_p2_q  <= qm_p2_d;
        n1q_p2_q <= n1q_p2_d;
        n0q_p2_q <= n0q_p2_d;
        if (reset) begin
            blank_p2_q <= 1'b1;
            ctrl_p2_q  <= 2'b00;
        end else begin
            blank_p2_q <= blank_p2_d;
            ctrl_p2_q  <= ctrl_p2_d;
        end
    end

    // ---- stage 3: DC balance against the running disparity
    always_comb begin
        qm8   = qm_p2_q[8];
        n1s   = $signed({1'b0, n1q_p2_q});
        n0s   = $signed({1'b0, n0q_p2_q});
        diff  = n1s - n0s;
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (blank_p2_q) begin
            sym_d = ctrl_symbol(ctrl_p2_q);
            cnt_d = C_dc_reset_on_blank ? '0 : cnt_q;
        end else if ((cnt_q == '0) || (n1q_p2_q == n0q_p2_q)) begin
            sym_d = {~qm8, qm8, qm8 ? qm_p2_q[7:0] : ~qm_p2_q[7:0]};
            cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 0) && (n1q_p2_q > n0q_p2_q)) ||
                     ((cnt_q < 0) && (n0q_p2_q > n1q_p2_q))) begin
            sym_d = {1'b1, qm8, ~qm_p2_q[7:0]};
            cnt_d = cnt_q + (qm8 ? CNT_TWO : '0) - diff;
        end else begin
            sym_d = {1'b0, qm8, qm_p2_q[7:0]};
            cnt_d = cnt_q - (qm8 ? '0 : CNT_TWO) + diff;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            sym_q <= CTRL_00;
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_symbol = sym_q;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Directed bench for tmds_encoder_pipe: hand-computed symbols and disparity values,
// plus a short random stretch checked by decoding the symbols back to pixels.
module tb_tmds_encoder_pipe;

    logic       clk_pixel;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] in_ctrl;
    logic       in_blank;
    logic [9:0] out_symbol;

    tmds_encoder_pipe dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_blank   (in_blank),
        .out_symbol (out_symbol)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    localparam int LAT   = 3;
    localparam int SLOTS = 4096;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;

    bit         s_v  [SLOTS];
    logic [9:0] s_e  [SLOTS];
    bit         c_v  [SLOTS];
    int         c_e  [SLOTS];
    bit         d_v  [SLOTS];
    logic [7:0] d_e  [SLOTS];
    bit         r_v  [SLOTS];
    string      tg   [SLOTS];

    logic [9:0] ctab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] b, d;
        b    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    // One pixel-clock slot: check outputs due now, then drive the next input.
    task automatic tick(input logic r, input logic b, input logic [1:0] c, input logic [7:0] d,
                        input bit se, input logic [9:0] sx, input bit ce, input int cx,
                        input bit de, input string tag);
        logic [9:0] obs_sym;
        int         obs_cnt;
        int         k;
        @(negedge clk_pixel);
        obs_sym = out_symbol;
        obs_cnt = $signed(dut.cnt_q);
        if (n >= 1 && r_v[n-1]) begin
            chk({tg[n-1], "_rst_sym"}, 32'(obs_sym), 32'h354);
            chk({tg[n-1], "_rst_cnt"}, obs_cnt, 0);
        end
        if (n >= LAT) begin
            k = n - LAT;
            if (s_v[k]) chk({tg[k], "_sym"}, 32'(obs_sym), 32'(s_e[k]));
            if (c_v[k]) chk({tg[k], "_cnt"}, obs_cnt, c_e[k]);
            if (d_v[k]) chk({tg[k], "_dec"}, 32'(decode(obs_sym)), 32'(d_e[k]));
            chk("cnt_range", 32'(obs_cnt >= -10 && obs_cnt <= 10), 32'd1);
        end
        reset    = r;
        in_blank = b;
        in_ctrl  = c;
        in_data  = d;
        s_v[n] = se; s_e[n] = sx; c_v[n] = ce; c_e[n] = cx;
        d_v[n] = de; d_e[n] = d;  r_v[n] = r;  tg[n]  = tag;
        n++;
    endtask

    task automatic px(input logic b, input logic [1:0] c, input logic [7:0] d,
                      input logic [9:0] sx, input int cx, input string tag);
        tick(1'b0, b, c, d, 1'b1, sx, 1'b1, cx, 1'b0, tag);
    endtask

    initial begin
        logic       rb;
        logic [1:0] rc;
        logic [7:0] rd;
        reset = 1'b1; in_blank = 1'b1; in_ctrl = 2'b00; in_data = 8'h00;

        tick(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 10'h354, 1'b1, 0, 1'b0, "reset0");
        tick(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 10'h354, 1'b1, 0, 1'b0, "reset1");
        for (int i = 0; i < 3; i++) px(1'b1, 2'b00, 8'h00, 10'h354, 0, "post_reset");

        px(1'b1, 2'b01, 8'h00, 10'h0AB, 0, "ctrl01");
        px(1'b1, 2'b10, 8'h00, 10'h154, 0, "ctrl10");
        px(1'b1, 2'b11, 8'h00, 10'h2AB, 0, "ctrl11");
        px(1'b1, 2'b00, 8'h00, 10'h354, 0, "ctrl00");

        px(1'b0, 2'b00, 8'h00, 10'h100, -8, "zero_a");
        px(1'b0, 2'b00, 8'h00, 10'h3FF,  2, "zero_b");
        px(1'b0, 2'b00, 8'h00, 10'h100, -6, "zero_c");
        px(1'b0, 2'b00, 8'h00, 10'h3FF,  4, "zero_d");

        px(1'b1, 2'b10, 8'hFF, 10'h154, 0, "blank_prio");
        px(1'b0, 2'b11, 8'hFF, 10'h200, -8, "ff_single");
        px(1'b1, 2'b00, 8'h00, 10'h354, 0, "ff_then_blank");

        px(1'b0, 2'b00, 8'h55, 10'h133,  0, "bal_cnt0");
        px(1'b0, 2'b00, 8'h00, 10'h100, -8, "bal_zero");
        px(1'b0, 2'b00, 8'h55, 10'h133, -8, "bal_cnt_neg");
        px(1'b0, 2'b00, 8'h00, 10'h3FF,  2, "inv_qm8_1");
        px(1'b0, 2'b00, 8'hFF, 10'h200, -6, "inv_qm8_0");
        px(1'b0, 2'b00, 8'hFF, 10'h0FF,  0, "plain_qm8_0");
        px(1'b1, 2'b01, 8'h00, 10'h0AB,  0, "blank_again");

        px(1'b0, 2'b00, 8'h00, 10'h100, -8, "mid_a");
        px(1'b0, 2'b00, 8'h00, 10'h3FF,  2, "mid_b");
        px(1'b0, 2'b00, 8'h00, 10'h354,  0, "mid_flush_a");
        px(1'b0, 2'b00, 8'h00, 10'h354,  0, "mid_flush_b");
        tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 1'b1, 0, 1'b0, "mid_reset");
        px(1'b0, 2'b00, 8'h00, 10'h100, -8, "resume_a");
        px(1'b0, 2'b00, 8'h00, 10'h3FF,  2, "resume_b");
        px(1'b1, 2'b00, 8'h00, 10'h354,  0, "resume_blank");

        for (int i = 0; i < 300; i++) begin
            rb = ($urandom_range(0, 3) == 0);
            rc = 2'($urandom);
            rd = 8'($urandom);
            if (rb) tick(1'b0, 1'b1, rc, rd, 1'b1, ctab[rc], 1'b1, 0, 1'b0, "rnd_blank");
            else    tick(1'b0, 1'b0, rc, rd, 1'b0, 10'h000, 1'b0, 0, 1'b1, "rnd_pixel");
        end

        for (int i = 0; i < LAT + 1; i++) begin
            tick(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 10'h000, 1'b0, 0, 1'b0, "drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
